// File: rtl/alu.sv
// Registered signed integer ALU: one operation per cycle, one-cycle latency.
// CMP updates only the flags and NOP opcodes hold both result and flags.
module alu #(
    parameter int W = 16
) (
    input  logic         clk,
    input  logic         rst,
    input  logic [4:0]   alu_op,
    input  logic [W-1:0] operandA,
    input  logic [W-1:0] operandB,
    output logic [W-1:0] resultAccumulator,
    output logic [3:0]   flags
);

    localparam int SW = $clog2(W);

    localparam logic [4:0] OP_ADD  = 5'b00000;
    localparam logic [4:0] OP_SUB  = 5'b00001;
    localparam logic [4:0] OP_MUL  = 5'b00010;
    localparam logic [4:0] OP_DIV  = 5'b00011;
    localparam logic [4:0] OP_AND  = 5'b00100;
    localparam logic [4:0] OP_OR   = 5'b00101;
    localparam logic [4:0] OP_XOR  = 5'b00110;
    localparam logic [4:0] OP_NOT  = 5'b00111;
    localparam logic [4:0] OP_CMP  = 5'b01000;
    localparam logic [4:0] OP_MOD  = 5'b01001;
    localparam logic [4:0] OP_LSL  = 5'b01010;
    localparam logic [4:0] OP_LSR  = 5'b01011;
    localparam logic [4:0] OP_ASR  = 5'b01100;
    localparam logic [4:0] OP_INC  = 5'b01101;
    localparam logic [4:0] OP_DEC  = 5'b01110;
    localparam logic [4:0] OP_PASS = 5'b01111;

    localparam logic [W-1:0] MIN_VAL = {1'b1, {(W-1){1'b0}}};
    localparam logic [W-1:0] ONE_VAL = {{(W-1){1'b0}}, 1'b1};

    // Signed overflow of a two's complement add: same-sign inputs, different-sign result.
    function automatic logic add_ovf(input logic sa, input logic sb, input logic sr);
        return (sa == sb) && (sr != sa);
    endfunction

    // Signed overflow of a subtract a-b: differing-sign inputs, result sign differs from a.
    function automatic logic sub_ovf(input logic sa, input logic sb, input logic sr);
        return (sa != sb) && (sr != sa);
    endfunction

    logic [W-1:0]          res_q, res_d;
    logic [3:0]            flags_q, flags_d;

    logic [W:0]            add_s, sub_s, inc_s, dec_s;
    logic signed [2*W-1:0] prod_s;
    logic                  mul_ovf_s;
    logic [SW-1:0]         sh_s;
    logic [W:0]            shl_s, shr_s;
    logic signed [W:0]     asr_s;
    logic                  b_zero_s, div_ovf_s;

    logic [W-1:0]          val_s;
    logic                  c_s, v_s, keep_res_s, nop_s;

    assign add_s     = {1'b0, operandA} + {1'b0, operandB};
    assign sub_s     = {1'b0, operandA} - {1'b0, operandB};
    assign inc_s     = {1'b0, operandA} + {1'b0, ONE_VAL};
    assign dec_s     = {1'b0, operandA} - {1'b0, ONE_VAL};
    assign prod_s    = $signed(operandA) * $signed(operandB);
    assign mul_ovf_s = (prod_s != {{W{prod_s[W-1]}}, prod_s[W-1:0]});
    assign b_zero_s  = (operandB == {W{1'b0}});
    assign div_ovf_s = (operandA == MIN_VAL) && (operandB == {W{1'b1}});

    // The extra guard bit on each shift catches the last bit shifted out (zero when S=0).
    assign sh_s  = operandB[SW-1:0];
    assign shl_s = {1'b0, operandA} << sh_s;
    assign shr_s = {operandA, 1'b0} >> sh_s;
    assign asr_s = $signed({operandA, 1'b0}) >>> sh_s;

    // Operation select: value to write, carry and overflow, and hold qualifiers.
    always_comb begin
        val_s      = {W{1'b0}};
        c_s        = 1'b0;
        v_s        = 1'b0;
        keep_res_s = 1'b0;
        nop_s      = 1'b0;
        case (alu_op)
            OP_ADD: begin
                val_s = add_s[W-1:0];
                c_s   = add_s[W];
                v_s   = add_ovf(operandA[W-1], operandB[W-1], add_s[W-1]);
            end
            OP_SUB, OP_CMP: begin
                val_s      = sub_s[W-1:0];
                c_s        = sub_s[W];
                v_s        = sub_ovf(operandA[W-1], operandB[W-1], sub_s[W-1]);
                keep_res_s = (alu_op == OP_CMP);
            end
            OP_MUL: begin
                val_s = prod_s[W-1:0];
                v_s   = mul_ovf_s;
            end
            OP_DIV: begin
                if (b_zero_s) begin
                    val_s = {W{1'b0}};
                    v_s   = 1'b1;
                end else if (div_ovf_s) begin
                    val_s = MIN_VAL;
                    v_s   = 1'b1;
                end else begin
                    val_s = $signed(operandA) / $signed(operandB);
                end
            end
            OP_MOD: begin
                if (b_zero_s) begin
                    val_s = {W{1'b0}};
                    v_s   = 1'b1;
                end else if (div_ovf_s) begin
                    val_s = {W{1'b0}};
                end else begin
                    val_s = $signed(operandA) % $signed(operandB);
                end
            end
            OP_AND:  val_s = operandA & operandB;
            OP_OR:   val_s = operandA | operandB;
            OP_XOR:  val_s = operandA ^ operandB;
            OP_NOT:  val_s = ~operandA;
            OP_LSL: begin
                val_s = shl_s[W-1:0];
                c_s   = shl_s[W];
            end
            OP_LSR: begin
                val_s = shr_s[W:1];
                c_s   = shr_s[0];
            end
            OP_ASR: begin
                val_s = asr_s[W:1];
                c_s   = asr_s[0];
            end
            OP_INC: begin
                val_s = inc_s[W-1:0];
                c_s   = inc_s[W];
                v_s   = add_ovf(operandA[W-1], 1'b0, inc_s[W-1]);
            end
            OP_DEC: begin
                val_s = dec_s[W-1:0];
                c_s   = dec_s[W];
                v_s   = sub_ovf(operandA[W-1], 1'b0, dec_s[W-1]);
            end
            OP_PASS: val_s = operandB;
            default: nop_s = 1'b1;
        endcase
    end

    // Next-state selection honouring CMP result hold and NOP full hold.
    always_comb begin
        if (nop_s) begin
            res_d   = res_q;
            flags_d = flags_q;
        end else if (keep_res_s) begin
            res_d   = res_q;
            flags_d = {(val_s == {W{1'b0}}), val_s[W-1], c_s, v_s};
        end else begin
            res_d   = val_s;
            flags_d = {(val_s == {W{1'b0}}), val_s[W-1], c_s, v_s};
        end
    end

    // Output register stage with synchronous reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            res_q   <= {W{1'b0}};
            flags_q <= 4'b0000;
        end else begin
            res_q   <= res_d;
            flags_q <= flags_d;
        end
    end

    assign resultAccumulator = res_q;
    assign flags             = flags_q;

endmodule

// File: tb/tb_alu.sv
// Randomised self-checking bench for alu (W=16) against an integer-arithmetic
// reference model, preceded by directed corner cases.
module tb_alu;

    localparam int W = 16;

    logic         clk;
    logic         rst;
    logic [4:0]   alu_op;
    logic [W-1:0] operandA;
    logic [W-1:0] operandB;
    logic [W-1:0] resultAccumulator;
    logic [3:0]   flags;

    int           n_checks;
    int           n_errors;
    logic [15:0]  m_res;
    logic [3:0]   m_flags;

    alu #(.W(W)) dut (
        .clk               (clk),
        .rst               (rst),
        .alu_op            (alu_op),
        .operandA          (operandA),
        .operandB          (operandB),
        .resultAccumulator (resultAccumulator),
        .flags             (flags)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s got %h expected %h", tag, got, exp);
        end
    endtask

    function automatic bit out_of_range(input int r);
        return (r > 32767) || (r < -32768);
    endfunction

    // Reference model built from plain integer arithmetic on the operand values.
    task automatic model_step(input logic [4:0] op, input logic [15:0] a, input logic [15:0] b);
        int          sa, sb, ua, ub, r, s;
        bit          c, v, wr, upd;
        logic [15:0] r16;
        sa = $signed(a);
        sb = $signed(b);
        ua = int'(a);
        ub = int'(b);
        s  = ub % 16;
        r  = 0;
        c  = 1'b0;
        v  = 1'b0;
        wr = 1'b1;
        upd = 1'b1;
        case (op)
            5'd0:  begin r = sa + sb; c = (ua + ub) > 65535; v = out_of_range(r); end
            5'd1:  begin r = sa - sb; c = ua < ub; v = out_of_range(r); end
            5'd2:  begin r = sa * sb; v = out_of_range(r); end
            5'd3:  begin
                if (sb == 0) begin r = 0; v = 1'b1; end
                else begin r = sa / sb; v = out_of_range(r); end
            end
            5'd4:  r = ua & ub;
            5'd5:  r = ua | ub;
            5'd6:  r = ua ^ ub;
            5'd7:  r = ~ua;
            5'd8:  begin r = sa - sb; c = ua < ub; v = out_of_range(r); wr = 1'b0; end
            5'd9:  begin
                if (sb == 0) begin r = 0; v = 1'b1; end
                else r = sa % sb;
            end
            5'd10: begin r = ua << s; c = (s != 0) ? ((ua >> (16 - s)) & 1) : 0; end
            5'd11: begin r = ua >> s; c = (s != 0) ? ((ua >> (s - 1)) & 1) : 0; end
            5'd12: begin r = sa >>> s; c = (s != 0) ? ((sa >>> (s - 1)) & 1) : 0; end
            5'd13: begin r = sa + 1; c = (ua + 1) > 65535; v = out_of_range(r); end
            5'd14: begin r = sa - 1; c = ua < 1; v = out_of_range(r); end
            5'd15: r = ub;
            default: begin wr = 1'b0; upd = 1'b0; end
        endcase
        r16 = r[15:0];
        if (upd) m_flags = {(r16 == 16'h0000), r16[15], c, v};
        if (wr)  m_res   = r16;
    endtask

    task automatic do_op(input logic [4:0] op, input logic [15:0] a, input logic [15:0] b);
        @(negedge clk);
        rst      = 1'b0;
        alu_op   = op;
        operandA = a;
        operandB = b;
        model_step(op, a, b);
        @(posedge clk);
        #1;
        chk("result", 32'(resultAccumulator), 32'(m_res));
        chk("flags", 32'(flags), 32'(m_flags));
    endtask

    task automatic do_reset(input logic [4:0] op, input logic [15:0] a, input logic [15:0] b);
        @(negedge clk);
        rst      = 1'b1;
        alu_op   = op;
        operandA = a;
        operandB = b;
        m_res    = 16'h0000;
        m_flags  = 4'b0000;
        @(posedge clk);
        #1;
        chk("rst_result", 32'(resultAccumulator), 32'h0);
        chk("rst_flags", 32'(flags), 32'h0);
    endtask

    task automatic dir(input string tag, input logic [4:0] op, input logic [15:0] a,
                       input logic [15:0] b, input logic [15:0] er, input logic [3:0] ef);
        do_op(op, a, b);
        chk({tag, "_res"}, 32'(resultAccumulator), 32'(er));
        chk({tag, "_flg"}, 32'(flags), 32'(ef));
    endtask

    function automatic logic [15:0] pick_operand();
        logic [15:0] corners [6];
        corners = '{16'h0000, 16'h0001, 16'hFFFF, 16'h8000, 16'h7FFF, 16'h000F};
        if ($urandom_range(0, 3) == 0) return corners[$urandom_range(0, 5)];
        return 16'($urandom);
    endfunction

    initial begin
        n_checks = 0;
        n_errors = 0;
        m_res    = 16'h0000;
        m_flags  = 4'b0000;
        rst      = 1'b1;
        alu_op   = 5'd0;
        operandA = 16'h0000;
        operandB = 16'h0000;

        do_reset(5'b00000, 16'd5, 16'd3);
        dir("add_after_rst", 5'b00000, 16'd5,      16'd3,      16'd8,      4'b0000);
        dir("mod_m32_5",     5'b01001, 16'hFFE0,   16'd5,      16'hFFFE,   4'b0100);
        dir("mod_m13_m3",    5'b01001, 16'hFFF3,   16'hFFFD,   16'hFFFF,   4'b0100);
        dir("mod_9_1",       5'b01001, 16'd9,      16'd1,      16'h0000,   4'b1000);
        dir("mod_16_11",     5'b01001, 16'd16,     16'd11,     16'd5,      4'b0000);
        dir("mod_16_m10",    5'b01001, 16'd16,     16'hFFF6,   16'd6,      4'b0000);
        dir("div_by0",       5'b00011, 16'd7,      16'd0,      16'h0000,   4'b1001);
        dir("mod_by0",       5'b01001, 16'd7,      16'd0,      16'h0000,   4'b1001);
        dir("add_ovf",       5'b00000, 16'h7FFF,   16'd1,      16'h8000,   4'b0101);
        dir("sub_borrow",    5'b00001, 16'd0,      16'd1,      16'hFFFF,   4'b0110);
        dir("div_min_m1",    5'b00011, 16'h8000,   16'hFFFF,   16'h8000,   4'b0101);
        dir("mod_min_m1",    5'b01001, 16'h8000,   16'hFFFF,   16'h0000,   4'b1000);
        dir("mul_ovf",       5'b00010, 16'd256,    16'd256,    16'h0000,   4'b1001);
        dir("lsl",           5'b01010, 16'h8001,   16'd1,      16'h0002,   4'b0010);
        dir("asr",           5'b01100, 16'h8000,   16'd15,     16'hFFFF,   4'b0100);
        dir("lsr",           5'b01011, 16'h8000,   16'd15,     16'h0001,   4'b0000);
        dir("pass",          5'b01111, 16'd0,      16'd42,     16'd42,     4'b0000);
        dir("cmp_hold",      5'b01000, 16'd5,      16'd5,      16'd42,     4'b1000);
        dir("nop_hold",      5'b11111, 16'h1234,   16'h5678,   16'd42,     4'b1000);

        do_reset(5'b01111, 16'hABCD, 16'hABCD);

        for (int i = 0; i < 3000; i++) begin
            if ($urandom_range(0, 199) == 0)
                do_reset(5'($urandom_range(0, 31)), pick_operand(), pick_operand());
            else if ($urandom_range(0, 4) == 0)
                do_op(5'($urandom_range(0, 31)), pick_operand(), pick_operand());
            else
                do_op(5'($urandom_range(0, 15)), pick_operand(), pick_operand());
        end

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule

// File: doc/alu.md
# alu

Parameterised signed integer ALU for the datapath, selected by a 5-bit opcode. It registers the selected operation on `operandA`/`operandB` into `resultAccumulator` and sets four status flags. All opcodes compute combinationally and commit on the next rising clock edge. Downstream logic (accumulator write-back, branch unit) reads the registered outputs.

## Interface
- `W`, default 16: operand/result width in bits (two's complement); must be ≥ 4.
- `clk`  in  1  rising-edge clock.
- `rst`  in  1  synchronous, active-high reset.
- `alu_op`  in  5  operation select.
- `operandA`  in  W  signed operand A.
- `operandB`  in  W  signed operand B.
- `resultAccumulator`  out  W  signed registered result.
- `flags`  out  4  registered status flags:
  - [3] Z: zero
  - [2] N: negative (result MSB)
  - [1] C: carry / borrow / last bit shifted out
  - [0] V: signed overflow or divide-by-zero

## Operation
Opcodes (S = shift amount = `operandB[$clog2(W)-1:0]`):
- 00000 ADD: A+B. C = unsigned carry out. V = signed overflow.
- 00001 SUB: A−B. C = 1 when A<B unsigned (borrow). V = signed overflow.
- 00010 MUL: low W bits of the signed 2W product. V = 1 if the product does not fit in signed W. C = 0.
- 00011 DIV: signed quotient, truncated toward zero.
- 00100 AND, 00101 OR, 00110 XOR: bitwise. C = V = 0.
- 00111 NOT: ~A. C = V = 0.
- 01000 CMP: flags from A−B as in SUB. `resultAccumulator` holds its previous value.
- 01001 MOD: signed remainder. Sign follows the dividend; magnitude = |A| mod |B|. Satisfies A = (A/B)·B + A%B with truncating division.
- 01010 LSL: A << S.
- 01011 LSR: logical right shift of A by S.
- 01100 ASR: arithmetic right shift of A by S.
  - Shifts: C = last bit shifted out; C = 0 when S = 0. V = 0.
- 01101 INC: A+1.
- 01110 DEC: A−1.
  - INC/DEC: C and V computed as ADD/SUB with B = 1.
- 01111 PASS: result = B. C = V = 0.
- 10000–11111: NOP. Result and flags hold.

Flag and boundary rules:
- Z and N are computed from the value written (for CMP, from the difference). This applies to every non-NOP opcode.
- DIV or MOD with B = 0: result = 0, V = 1, C = 0, Z = 1.
- DIV with A = −2^(W−1), B = −1: result = −2^(W−1), V = 1.
- MOD with A = −2^(W−1), B = −1: result = 0, V = 0.
- DIV/MOD C = 0 except as stated above.
- No operation depends on prior state except CMP (result hold) and NOP (full hold).

## Timing
- Fully combinational compute; a single register stage for `resultAccumulator` and `flags`.
- Latency 1 cycle: operands/opcode sampled at rising edge k appear at the outputs after edge k.
- New operation accepted every cycle. No handshake.
- `rst` high at a rising edge: `resultAccumulator` = 0, `flags` = 4'b0000. Reset overrides any opcode in that cycle.
- Reset has priority when asserted mid-stream. The first post-reset result reflects inputs at the first edge with `rst` low.
- Inputs need only be stable setup/hold around the rising edge.

## Test plan
- Reset: assert `rst` one cycle with A=5, B=3, ADD → `resultAccumulator`=0, `flags`=0. Release → next edge gives 8, flags 0000.
- MOD signs (W=16, one per cycle):
  - −32%5 → −2, N=1
  - −13%−3 → −1, N=1
  - 9%1 → 0, Z=1
  - 16%11 → 5
  - 16%−10 → 6
- Divide-by-zero: DIV 7/0 and MOD 7/0 → result 0, flags Z=1, V=1 (1001).
- Overflow:
  - ADD 32767+1 → −32768, N=1, V=1.
  - SUB 0−1 → −1, C=1, N=1.
  - DIV −32768/−1 → −32768, V=1.
  - MUL 256·256 → 0, V=1, Z=1.
- Shifts: LSL 0x8001 by 1 → 0x0002, C=1. ASR 0x8000 by 15 → 0xFFFF, C=0, N=1. LSR 0x8000 by 15 → 0x0001.
- Holds: after PASS B=42, CMP 5 vs 5 → result stays 42, Z=1. Opcode 11111 → result and flags unchanged.
